i_execute: RTL and testbench
============================

// Module: i_execute
// PURPOSE
//  EX stage: consumer side of the ID/EX pipeline interface. Decodes ALU control from ex_ctl + funct,
//  executes ALU ops (incl. iterative multi-cycle MULT), computes branch target, drives EX/MEM register.
//  Sits between the decode stage's ID/EX latch and the memory stage; stalls decode during MULT.
// PARAMETERS
//  DATA_W   32  datapath width; MULT takes DATA_W cycles (1 shift-add step/cycle)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  id_valid       in   1   ID/EX holds a real instruction (0 = bubble)
//  ex_flush       in   1   kill incoming instruction and abort any MULT in progress
//  wb_ctl         in   2   {regwrite, memtoreg}
//  m_ctl          in   3   {branch, memread, memwrite}
//  ex_ctl         in   4   {regdst, aluop[1:0], alusrc}
//  npc            in   DATA_W  PC+4 of instruction
//  rdata1         in   DATA_W  rs value
//  rdata2         in   DATA_W  rt value
//  s_extend       in   DATA_W  sign-extended imm; [5:0] = funct
//  instr_2016     in   5   rt field
//  instr_1511     in   5   rd field
//  ex_stall       out  1   1 = upstream must hold ID/EX contents
//  wb_ctlout      out  2   EX/MEM wb control
//  m_ctlout       out  3   EX/MEM mem control
//  add_result     out  DATA_W  branch target
//  zero           out  1   alu_result == 0
//  alu_result     out  DATA_W  ALU/MULT result
//  rdata2out      out  DATA_W  store data (rt)
//  dest_reg       out  5   writeback register number
// BEHAVIOUR
//  Reset (reset=0, async): every output 0, state IDLE, MULT counter 0. Deassertion sync to clk.
//  ALU op: aluop 00 add; 01 sub; 11 add; 10 by funct: 100000 add, 100010 sub, 100100 and,
//   100101 or, 101010 slt (signed, result 0/1), 011000 MULT; other funct -> add.
//  Operand B = alusrc ? s_extend : rdata2. dest_reg = regdst ? instr_1511 : instr_2016.
//  add_result = npc + (s_extend << 2), mod 2^DATA_W. Add/sub wrap, no overflow trap.
//  States: IDLE, MUL. ex_stall = (state == MUL); registered, never combinational from inputs.
//  IDLE, each edge: ex_flush=1 or id_valid=0 -> EX/MEM loads bubble (all outputs 0).
//   Valid non-MULT -> EX/MEM loads results; latency 1 edge.
//   Valid MULT -> capture operands, control, dest into internal regs; EX/MEM loads bubble; go MUL, cnt=0.
//  MUL: one shift-add step/edge, cnt++; inputs ignored (upstream holds). EX/MEM loads bubble each edge
//   until the edge where cnt==DATA_W-1: EX/MEM loads product low DATA_W bits (unsigned) with captured
//   wb/m ctl, dest_reg, rdata2; zero from product; add_result from captured npc/imm; -> IDLE.
//   Result visible DATA_W edges after acceptance edge; ex_stall high for exactly DATA_W cycles.
//  ex_flush in MUL: abort, EX/MEM bubble, -> IDLE next edge; ex_stall low next cycle.
//  Priority: reset > ex_flush > MULT completion > new instruction. Held instr after MULT issues
//   normally in first IDLE cycle.
//  Reset mid-MULT: immediate abort, outputs 0, no result ever emitted.
// TESTING
//  ADD: aluop=10,funct=100000,rdata1=5,rdata2=7,regdst=1,rd=3 -> next edge alu_result=12,dest_reg=3,zero=0.
//  BEQ: aluop=01,rdata1=rdata2=9,npc=0x100,imm=4,m_ctl=100 -> zero=1, add_result=0x110, m_ctlout=100.
//  SLT: rdata1=0xFFFFFFFF,rdata2=1 -> alu_result=1; swapped -> 0; lw alusrc=1 imm=-4,rs=0x20 -> 0x1C.
//  MULT 6x7 then ADD queued: ex_stall high 32 cycles, bubbles, then alu_result=42, ADD result next edge.
//  Flush at MULT cycle 10 -> bubble, ex_stall low next cycle, 42 never appears; id_valid=0 -> all 0.
//  Async reset asserted mid-MULT, between edges -> outputs 0 immediately, ex_stall=0.

Source files
------------

// File: rtl/i_execute.sv
// EX stage: ALU decode/execute, branch target, iterative shift-add MULT,
// and the EX/MEM pipeline register. Stalls decode while a MULT is in flight.
module i_execute #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              ex_flush,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic [3:0]        ex_ctl,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [4:0]        instr_2016,
  input  logic [4:0]        instr_1511,
  output logic              ex_stall,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic [DATA_W-1:0] add_result,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [4:0]        dest_reg
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  logic [1:0]        mul_wb;
  logic [2:0]        mul_m;
  logic [DATA_W-1:0] mul_add;
  logic [DATA_W-1:0] mul_rd2;
  logic [4:0]        mul_dest;

  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_val;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] step_acc;
  logic [4:0]        dest_sel;
  logic              is_mult;
  logic              slt;

  always_comb begin
    aluop    = ex_ctl[2:1];
    funct    = s_extend[5:0];
    op_b     = ex_ctl[0] ? s_extend : rdata2;
    dest_sel = ex_ctl[3] ? instr_1511 : instr_2016;
    target   = npc + (s_extend << 2);
    is_mult  = (aluop == 2'b10) && (funct == 6'b011000);
    slt      = $signed(rdata1) < $signed(op_b);
    alu_val  = rdata1 + op_b;
    case (aluop)
      2'b01: alu_val = rdata1 - op_b;
      2'b10: begin
        case (funct)
          6'b100010: alu_val = rdata1 - op_b;
          6'b100100: alu_val = rdata1 & op_b;
          6'b100101: alu_val = rdata1 | op_b;
          6'b101010: alu_val = {{(DATA_W-1){1'b0}}, slt};
          default:   alu_val = rdata1 + op_b;
        endcase
      end
      default: alu_val = rdata1 + op_b;
    endcase
    // Accumulator value after this cycle's shift-add step; also the final product.
    step_acc = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      mul_wb     <= '0;
      mul_m      <= '0;
      mul_add    <= '0;
      mul_rd2    <= '0;
      mul_dest   <= '0;
      ex_stall   <= 1'b0;
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      dest_reg   <= '0;
    end else begin
      // Bubble by default; the branches below overwrite when a result retires.
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      dest_reg   <= '0;
      if (ex_flush) begin
        state    <= IDLE;
        ex_stall <= 1'b0;
        cnt      <= '0;
      end else if (state == MUL) begin
        acc    <= step_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_W'(DATA_W-1)) begin
          wb_ctlout  <= mul_wb;
          m_ctlout   <= mul_m;
          add_result <= mul_add;
          zero       <= (step_acc == '0);
          alu_result <= step_acc;
          rdata2out  <= mul_rd2;
          dest_reg   <= mul_dest;
          state      <= IDLE;
          ex_stall   <= 1'b0;
          cnt        <= '0;
        end
      end else if (id_valid) begin
        if (is_mult) begin
          mcand    <= rdata1;
          mplier   <= op_b;
          acc      <= '0;
          mul_wb   <= wb_ctl;
          mul_m    <= m_ctl;
          mul_add  <= target;
          mul_rd2  <= rdata2;
          mul_dest <= dest_sel;
          cnt      <= '0;
          state    <= MUL;
          ex_stall <= 1'b1;
        end else begin
          wb_ctlout  <= wb_ctl;
          m_ctlout   <= m_ctl;
          add_result <= target;
          zero       <= (alu_val == '0);
          alu_result <= alu_val;
          rdata2out  <= rdata2;
          dest_reg   <= dest_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_i_execute.sv
// Bench for i_execute: directed cases plus random traffic checked every cycle
// against a transaction-level model (countdown timer, product via '*').
module tb_i_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, ex_flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0]  instr_2016, instr_1511;
  logic        ex_stall;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result, alu_result, rdata2out;
  logic        zero;
  logic [4:0]  dest_reg;

  i_execute #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .ex_flush(ex_flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl), .npc(npc),
    .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .instr_2016(instr_2016), .instr_1511(instr_1511), .ex_stall(ex_stall),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .dest_reg(dest_reg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: expected EX/MEM contents plus a pending MULT
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [31:0] e_add, e_alu, e_rd2;
  logic        e_zero, e_stall;
  logic [4:0]  e_dest;
  bit          busy;
  int          left;
  logic [1:0]  s_wb;
  logic [2:0]  s_m;
  logic [31:0] s_add, s_rd2, s_prod;
  logic [4:0]  s_dest;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("stall", 32'(ex_stall), 32'(e_stall));
    checkOutput("wb",    32'(wb_ctlout), 32'(e_wb));
    checkOutput("m",     32'(m_ctlout), 32'(e_m));
    checkOutput("add",   add_result, e_add);
    checkOutput("zero",  32'(zero), 32'(e_zero));
    checkOutput("alu",   alu_result, e_alu);
    checkOutput("rd2",   rdata2out, e_rd2);
    checkOutput("dest",  32'(dest_reg), 32'(e_dest));
  endtask

  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    case (fn)
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic setBubble();
    e_wb = '0; e_m = '0; e_add = '0; e_zero = 1'b0; e_alu = '0; e_rd2 = '0; e_dest = '0;
  endtask

  task automatic modelReset();
    setBubble();
    busy = 1'b0; left = 0; e_stall = 1'b0;
  endtask

  // One clock edge of the model, using the inputs currently applied
  task automatic modelStep();
    logic [31:0] b, res;
    setBubble();
    b = ex_ctl[0] ? s_extend : rdata2;
    if (ex_flush) begin
      busy = 1'b0;
    end else if (busy) begin
      left--;
      if (left == 0) begin
        busy = 1'b0;
        e_wb = s_wb; e_m = s_m; e_add = s_add; e_rd2 = s_rd2; e_dest = s_dest;
        e_alu = s_prod; e_zero = (s_prod == 0);
      end
    end else if (id_valid) begin
      if (ex_ctl[2:1] == 2'b10 && s_extend[5:0] == 6'h18) begin
        busy = 1'b1; left = 32;
        s_wb = wb_ctl; s_m = m_ctl; s_add = npc + s_extend * 4; s_rd2 = rdata2;
        s_dest = ex_ctl[3] ? instr_1511 : instr_2016;
        s_prod = rdata1 * b;
      end else begin
        res = refAlu(ex_ctl[2:1], s_extend[5:0], rdata1, b);
        e_wb = wb_ctl; e_m = m_ctl; e_add = npc + s_extend * 4; e_rd2 = rdata2;
        e_dest = ex_ctl[3] ? instr_1511 : instr_2016;
        e_alu = res; e_zero = (res == 0);
      end
    end
    e_stall = busy;
  endtask

  task automatic applyStimulus(input logic v, input logic f, input logic [1:0] wb,
                               input logic [2:0] m, input logic [3:0] ex,
                               input logic [31:0] n, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] se,
                               input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; ex_flush = f; wb_ctl = wb; m_ctl = m; ex_ctl = ex; npc = n;
    rdata1 = r1; rdata2 = r2; s_extend = se; instr_2016 = rt; instr_1511 = rd;
  endtask

  // Called at a falling edge: model the next rising edge, then check at the following falling edge
  task automatic stepCycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall_cycles;
    bit seen42;
    logic [31:0] fn;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    reset = 1'b1;

    // ADD
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h4, 5, 7, 32'h20, 5'd2, 5'd3);
    stepCycle();
    checkOutput("add_alu", alu_result, 32'd12);
    checkOutput("add_dest", 32'(dest_reg), 32'd3);
    checkOutput("add_zero", 32'(zero), 32'd0);

    // BEQ
    applyStimulus(1, 0, 2'b00, 3'b100, 4'b0010, 32'h100, 9, 9, 32'h4, 5'd9, 5'd0);
    stepCycle();
    checkOutput("beq_zero", 32'(zero), 32'd1);
    checkOutput("beq_tgt", add_result, 32'h110);
    checkOutput("beq_m", 32'(m_ctlout), 32'h4);

    // SLT both ways, then lw address
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hFFFF_FFFF, 1, 32'h2a, 5'd1, 5'd4);
    stepCycle();
    checkOutput("slt_neg", alu_result, 32'd1);
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h8, 1, 32'hFFFF_FFFF, 32'h2a, 5'd1, 5'd4);
    stepCycle();
    checkOutput("slt_swap", alu_result, 32'd0);
    applyStimulus(1, 0, 2'b11, 3'b010, 4'b0001, 32'hC, 32'h20, 32'h55, 32'hFFFF_FFFC, 5'd7, 5'd0);
    stepCycle();
    checkOutput("lw_addr", alu_result, 32'h1C);
    checkOutput("lw_dest", 32'(dest_reg), 32'd7);

    // MULT 6x7 followed by a held ADD
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h10, 6, 7, 32'h18, 5'd0, 5'd5);
    stepCycle();
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h14, 5, 7, 32'h20, 5'd0, 5'd6);
    stall_cycles = 0;
    while (ex_stall && stall_cycles < 40) begin
      stall_cycles++;
      stepCycle();
    end
    checkOutput("mul_stall_len", 32'(stall_cycles), 32'd32);
    checkOutput("mul_prod", alu_result, 32'd42);
    checkOutput("mul_dest", 32'(dest_reg), 32'd5);
    stepCycle();
    checkOutput("post_mul_add", alu_result, 32'd12);
    checkOutput("post_mul_dest", 32'(dest_reg), 32'd6);

    // Flush at MULT cycle 10
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h18, 6, 7, 32'h18, 5'd0, 5'd5);
    stepCycle();
    for (int i = 0; i < 9; i++) stepCycle();
    ex_flush = 1'b1;
    id_valid = 1'b0;
    stepCycle();
    checkOutput("flush_stall", 32'(ex_stall), 32'd0);
    checkOutput("flush_alu", alu_result, 32'd0);
    ex_flush = 1'b0;
    seen42 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (alu_result == 32'd42) seen42 = 1'b1;
    end
    checkOutput("flush_no_42", 32'(seen42), 32'd0);

    // Async reset in the middle of a MULT
    applyStimulus(1, 0, 2'b10, 3'b000, 4'b1100, 32'h18, 6, 7, 32'h18, 5'd0, 5'd5);
    stepCycle();
    for (int i = 0; i < 5; i++) stepCycle();
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_stall", 32'(ex_stall), 32'd0);
    checkOutput("rst_wb", 32'(wb_ctlout), 32'd0);
    checkOutput("rst_dest", 32'(dest_reg), 32'd0);
    checkAll();
    id_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen42 = 1'b0;
    for (int i = 0; i < 35; i++) begin
      stepCycle();
      if (alu_result == 32'd42) seen42 = 1'b1;
    end
    checkOutput("rst_no_42", 32'(seen42), 32'd0);

    // Random traffic; inputs are held while the model says the stage is stalled
    for (int it = 0; it < 1500; it++) begin
      if (busy) begin
        ex_flush = ($urandom_range(0, 39) == 0);
      end else begin
        case ($urandom_range(0, 7))
          0: fn = 32'h20;
          1: fn = 32'h22;
          2: fn = 32'h24;
          3: fn = 32'h25;
          4: fn = 32'h2a;
          5: fn = 32'h18;
          6: fn = {$urandom} & 32'h0000_003F;
          default: fn = $urandom;
        endcase
        applyStimulus(($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0),
                      2'($urandom), 3'($urandom), 4'($urandom), $urandom,
                      ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)),
                      ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)),
                      fn, 5'($urandom), 5'($urandom));
      end
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
